// File: rtl/weight_load_ctrl.sv
// Weight register load sequencer: clears the kernel registers, then streams NUM_REGS weights in.
// Optional build macro WLOAD_ZERO_SKIP_EN suppresses write enables for zero-valued weights.
module weight_load_ctrl #(
    parameter int F_WIDTH   = 8,
    parameter int NUM_REGS  = 9,
    parameter int IDX_WIDTH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 w_valid_i,
    input  logic [F_WIDTH-1:0]   w_data_i,
    output logic                 w_ready_o,
    output logic [F_WIDTH-1:0]   f_weight_o,
    output logic [NUM_REGS-1:0]  wreg_wr_en_o,
    output logic                 wreg_rst_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [IDX_WIDTH-1:0] idx_o
);

    typedef enum logic [1:0] {IDLE, CLEAR, LOAD, DONE} state_e;

    state_e               state_q, state_d;
    logic [IDX_WIDTH-1:0] idx_q, idx_d;
    logic [F_WIDTH-1:0]   f_weight_q, f_weight_d;
    logic [NUM_REGS-1:0]  wr_en_q, wr_en_d;
    logic                 wreg_rst_q, wreg_rst_d;
    logic                 done_q, done_d;
    logic                 hs, last, skip;

    always_comb begin
        hs   = (state_q == LOAD) && w_valid_i;
        last = (idx_q == IDX_WIDTH'(NUM_REGS - 1));
`ifdef WLOAD_ZERO_SKIP_EN
        // A zero weight is already held by the register since the CLEAR cycle.
        skip = (w_data_i == '0);
`else
        skip = 1'b0;
`endif
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        f_weight_d = f_weight_q;
        wr_en_d    = '0;
        wreg_rst_d = 1'b0;
        done_d     = 1'b0;
        if (abort_i && (state_q != IDLE)) begin
            state_d    = IDLE;
            idx_d      = '0;
            wreg_rst_d = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d    = CLEAR;
                        idx_d      = '0;
                        wreg_rst_d = 1'b1;
                    end
                end
                CLEAR: begin
                    state_d = LOAD;
                    idx_d   = '0;
                end
                LOAD: begin
                    if (hs) begin
                        f_weight_d = w_data_i;
                        if (!skip) wr_en_d = NUM_REGS'(1) << idx_q;
                        // Index returns to 0 after the final weight rather than wrapping mid-load.
                        if (last) begin
                            state_d = DONE;
                            idx_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            idx_d = idx_q + IDX_WIDTH'(1);
                        end
                    end
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            f_weight_q <= '0;
            wr_en_q    <= '0;
            wreg_rst_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            f_weight_q <= f_weight_d;
            wr_en_q    <= wr_en_d;
            wreg_rst_q <= wreg_rst_d;
            done_q     <= done_d;
        end
    end

    assign w_ready_o    = (state_q == LOAD);
    assign busy_o       = (state_q == CLEAR) || (state_q == LOAD);
    assign f_weight_o   = f_weight_q;
    assign wreg_wr_en_o = wr_en_q;
    assign wreg_rst_o   = wreg_rst_q;
    assign done_o       = done_q;
    assign idx_o        = idx_q;

endmodule

// File: doc/weight_load_ctrl.md
WEIGHT_LOAD_CTRL -- requirements
Module: weight_load_ctrl

Interface
REQ-001 The block SHALL have parameter F_WIDTH, default 8, giving the weight data width.
REQ-002 The block SHALL have parameter NUM_REGS, default 9, giving the number of weight registers sequenced (one kernel).
REQ-003 The block SHALL have parameter IDX_WIDTH, default 4, giving the index counter width; IDX_WIDTH SHALL satisfy 2^IDX_WIDTH > NUM_REGS.
REQ-004 The block SHALL have these ports:
- clk_i  input  1  clock; all state updates on the rising edge
- rst_n_i  input  1  asynchronous reset, active-low
- start_i  input  1  pulse; begins a kernel load when in IDLE
- abort_i  input  1  cancels any load in progress
- w_valid_i  input  1  weight stream valid
- w_data_i  input  F_WIDTH  signed weight stream data
- w_ready_o  output  1  weight stream ready
- f_weight_o  output  F_WIDTH  signed weight broadcast to all weight registers
- wreg_wr_en_o  output  NUM_REGS  one-hot write enable, bit k drives register k
- wreg_rst_o  output  1  clear to all weight registers, active-high, sampled synchronously by them
- busy_o  output  1  high in CLEAR and LOAD
- done_o  output  1  one-cycle pulse when a load completes
- idx_o  output  IDX_WIDTH  index of the next register to be written

Function
REQ-005 The FSM SHALL have the states IDLE, CLEAR, LOAD and DONE.
REQ-006 The FSM transitions SHALL be:
- IDLE -> CLEAR on start_i
- CLEAR -> LOAD after exactly one cycle
- LOAD -> DONE on the handshake that accepts weight index NUM_REGS-1
- DONE -> IDLE after one cycle
REQ-007 wreg_rst_o SHALL be high exactly during the CLEAR cycle; in that cycle idx SHALL be set to 0.
REQ-008 w_ready_o SHALL be high only in LOAD; a handshake occurs when w_valid_i and w_ready_o are both high.
REQ-009 On a handshake, in the following cycle f_weight_o SHALL equal the accepted w_data_i and wreg_wr_en_o SHALL equal one-hot(idx); idx SHALL then increment (registered outputs, 1-cycle latency).
REQ-010 wreg_wr_en_o SHALL be all-zero in every cycle not following a handshake; f_weight_o SHALL hold its last value.
REQ-011 A cycle in LOAD with w_valid_i low SHALL stall: no write enable and no idx change.
REQ-012 done_o SHALL be high for the single DONE cycle, which is the same cycle as the last write enable.
REQ-013 start_i outside IDLE SHALL be ignored.
REQ-014 abort_i in CLEAR, LOAD or DONE SHALL force IDLE on the next edge, set idx to 0, assert wreg_rst_o for that one cycle, and suppress both done_o and wreg_wr_en_o. abort_i SHALL take priority over a simultaneous handshake or start_i; abort_i in IDLE SHALL have no effect.
REQ-015 idx SHALL never exceed NUM_REGS-1 while in LOAD; no wrap-around SHALL occur within a single load.

Reset
REQ-016 While rst_n_i is low the block SHALL hold state IDLE, idx=0, f_weight_o=0, wreg_wr_en_o=0, wreg_rst_o=0, w_ready_o=0, busy_o=0 and done_o=0; assertion takes effect immediately, without waiting for a clock edge.
REQ-017 The first clock edge after rst_n_i deasserts SHALL see the block in IDLE and able to accept start_i.

Configuration
REQ-018 With macro WLOAD_ZERO_SKIP_EN defined, a handshake carrying w_data_i == 0 SHALL advance idx but SHALL NOT assert any wreg_wr_en_o bit; the register keeps the 0 written by the CLEAR cycle (sparse power saving). A zero final weight SHALL still produce done_o.
REQ-019 Without WLOAD_ZERO_SKIP_EN defined, every handshake SHALL assert its write enable regardless of data value.

Verification
REQ-020 Scenario: reset, then start_i, then 9 back-to-back weights 1..9 -> wreg_rst_o high for 1 cycle; wreg_wr_en_o = 0x001..0x100 with f_weight_o = 1..9; done_o coincides with 0x100.
REQ-021 Scenario: w_valid_i low for 3 cycles after weight 4 -> no enables and idx_o = 4 held; load then completes normally.
REQ-022 Scenario: abort_i asserted together with handshake of weight 6 -> no write for index 5; wreg_rst_o pulses; state IDLE; idx_o = 0; no done_o.
REQ-023 Scenario: weights {0,-128,0,127,0,0,0,0,5}, with and without WLOAD_ZERO_SKIP_EN -> with the macro, enables only on bits 1, 3 and 8; without it, 9 enables; done_o in both builds.
REQ-024 Scenario: start_i pulsed during LOAD, then rst_n_i pulled low mid-load -> the start is ignored; on reset all outputs are 0 without waiting for a clock edge, and a new start_i after release loads correctly.
